// File: rtl/sram_access_ctrl.sv
// Two-port round-robin arbiter and phase sequencer for one 32-bit SRAM macro (32/16/8-bit access).
// Optional feature macro SRAM_CTRL_ERR_EN: adds rsp_err and rejects conf=11 without macro activity.
module sram_access_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PRE_CYC = 1,
  parameter int unsigned WL_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [1:0]        a_conf,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [1:0]        b_conf,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [31:0]       rsp_rdata,
`ifdef SRAM_CTRL_ERR_EN
  output logic              rsp_err,
`endif
  output logic              sram_pre_en,
  output logic              sram_wl_en,
  output logic              sram_we,
  output logic              sram_sae,
  output logic [ADDR_W-3:0] sram_row,
  output logic [3:0]        sram_bl_mask,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int unsigned     CntW     = 8;
  localparam logic [CntW-1:0] PreLast  = CntW'(PRE_CYC - 1);
  localparam logic [CntW-1:0] WlLast   = CntW'(WL_CYC - 1);
  localparam logic [1:0]      Conf32   = 2'b00;
  localparam logic [1:0]      Conf16   = 2'b01;
  localparam logic [1:0]      Conf8    = 2'b10;
  localparam logic [1:0]      ConfRsvd = 2'b11;

  typedef enum logic [2:0] {StIdle, StPre, StAcc, StSense, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_b_q;
  logic              id_q, we_q;
  logic [1:0]        conf_q, sel_q;
  logic [ADDR_W-3:0] row_q;
  logic [31:0]       wdata_q, rdata_q;
`ifdef SRAM_CTRL_ERR_EN
  logic              err_q;
`endif

  logic              grant_a, grant_b, in_idle, accept;
  logic              req_we, req_err;
  logic [1:0]        req_conf, req_eff_conf;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        lane_mask;
  logic [7:0]        rd_byte;
  logic [31:0]       rd_aligned;

  function automatic logic [31:0] replicate(logic [1:0] conf, logic [31:0] d);
    logic [31:0] r;
    unique case (conf)
      Conf8:   r = {4{d[7:0]}};
      Conf16:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // On a tie the requester not served last wins; last_b_q resets to B so A wins first.
  always_comb begin
    in_idle = (state_q == StIdle);
    grant_a = a_valid & (~b_valid | last_b_q);
    grant_b = b_valid & (~a_valid | ~last_b_q);
    a_ready = in_idle & grant_a;
    b_ready = in_idle & grant_b;
    accept  = a_ready | b_ready;
  end

  always_comb begin
    req_we       = b_ready ? b_we    : a_we;
    req_conf     = b_ready ? b_conf  : a_conf;
    req_addr     = b_ready ? b_addr  : a_addr;
    req_wdata    = b_ready ? b_wdata : a_wdata;
    req_eff_conf = (req_conf == ConfRsvd) ? Conf32 : req_conf;
`ifdef SRAM_CTRL_ERR_EN
    req_err      = (req_conf == ConfRsvd);
`else
    req_err      = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = req_err ? StResp : StPre;
        end
      end
      StPre: begin
        if (cnt_q == PreLast) begin
          cnt_d   = '0;
          state_d = StAcc;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAcc: begin
        if (cnt_q == WlLast) begin
          cnt_d   = '0;
          state_d = we_q ? StResp : StSense;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSense: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Active-low lane enables: a cleared bit selects the lane.
  always_comb begin
    unique case (conf_q)
      Conf16:  lane_mask = sel_q[0] ? 4'b0011 : 4'b1100;
      Conf8:   lane_mask = ~(4'b0001 << sel_q);
      default: lane_mask = 4'b0000;
    endcase
  end

  always_comb begin
    unique case (sel_q)
      2'd0:    rd_byte = sram_rdata[7:0];
      2'd1:    rd_byte = sram_rdata[15:8];
      2'd2:    rd_byte = sram_rdata[23:16];
      default: rd_byte = sram_rdata[31:24];
    endcase
    unique case (conf_q)
      Conf8:   rd_aligned = {24'h0, rd_byte};
      Conf16:  rd_aligned = {16'h0, sel_q[0] ? sram_rdata[31:16] : sram_rdata[15:0]};
      default: rd_aligned = sram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      conf_q   <= Conf32;
      sel_q    <= 2'b00;
      row_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef SRAM_CTRL_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_b_q <= b_ready;
        id_q     <= b_ready;
        we_q     <= req_we;
        conf_q   <= req_eff_conf;
        sel_q    <= req_addr[1:0];
        row_q    <= req_addr[ADDR_W-1:2];
        wdata_q  <= replicate(req_eff_conf, req_wdata);
        rdata_q  <= '0;
`ifdef SRAM_CTRL_ERR_EN
        err_q    <= req_err;
`endif
      end
      if (state_q == StSense) begin
        rdata_q <= rd_aligned;
      end
    end
  end

  always_comb begin
    sram_pre_en  = (state_q == StPre);
    sram_wl_en   = (state_q == StAcc);
    sram_we      = (state_q == StAcc) & we_q;
    sram_sae     = (state_q == StSense);
    sram_bl_mask = (state_q == StAcc) ? lane_mask : 4'b1111;
    sram_row     = row_q;
    sram_wdata   = wdata_q;
    rsp_valid    = (state_q == StResp);
    rsp_id       = rsp_valid & id_q;
    rsp_rdata    = rsp_valid ? rdata_q : 32'h0;
`ifdef SRAM_CTRL_ERR_EN
    rsp_err      = rsp_valid & err_q;
`endif
  end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Access sequencer and two-port arbiter for one 32-bit SRAM macro with configurable access width (32/16/8 bits). Round-robin arbitration between requesters A and B. Drives the macro's precharge, wordline, write and sense-enable phases, and generates the active-low per-byte bitline mask. Returns right-justified read data with a one-cycle response strobe.

## Interface
- ADDR_W, 8: request address width. `addr[ADDR_W-1:2]` = row; `addr[1:0]` = lane select.
- PRE_CYC, 1: precharge cycles (≥1).
- WL_CYC, 2: wordline-active cycles (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, sampled on the rising edge of clk
- a_valid / b_valid  in  1  request valid
- a_ready / b_ready  out  1  request accepted this cycle
- a_we / b_we  in  1  1 = write
- a_conf / b_conf  in  2  00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = reserved
- a_addr / b_addr  in  ADDR_W  request address
- a_wdata / b_wdata  in  32  right-justified write data
- rsp_valid  out  1  response strobe, one cycle, no backpressure
- rsp_id  out  1  0 = A, 1 = B
- rsp_rdata  out  32  right-justified read data; 0 for writes
- sram_pre_en, sram_wl_en, sram_we, sram_sae  out  1  macro phase controls
- sram_row  out  ADDR_W-2  row address
- sram_bl_mask  out  4  per-lane mask; 0 = lane enabled
- sram_wdata  out  32  lane-replicated write data
- sram_rdata  in  32  macro read data

## Operation
- FSM states: IDLE, PRE, ACC, SENSE, RESP.
- **IDLE**
  - Grant at most one requester per cycle.
  - If both are valid, grant the one not served last. The last-served bit resets to B, so A wins the first tie.
  - `x_ready` = IDLE & `x_valid` & granted.
  - On acceptance, register id, we, conf, row, lane select and replicated wdata, then go to PRE.
- **PRE**: `sram_pre_en=1` for PRE_CYC cycles, then ACC.
- **ACC**: `sram_wl_en=1` for WL_CYC cycles. `sram_we` = registered we. `sram_bl_mask` = decoded mask.
  - Writes go to RESP.
  - Reads go to SENSE.
- **SENSE**: `sram_sae=1` for one cycle. `sram_rdata` is captured at the end of this cycle, then RESP.
- **RESP**: `rsp_valid=1` for one cycle with id and data, then IDLE.
- Mask decode (lane n = bit n):
  - 32-bit: 0000.
  - 16-bit: sel[0]=0 → 1100; sel[0]=1 → 0011.
  - 8-bit: only bit sel[1:0] cleared (e.g. sel=2 → 1011).
  - Outside ACC the mask is 1111.
- Write data replication:
  - 8-bit: `{4{wdata[7:0]}}`.
  - 16-bit: `{2{wdata[15:0]}}`.
  - 32-bit: unchanged.
- Read alignment:
  - 8-bit: selected lane → [7:0], upper bits 0.
  - 16-bit: selected half → [15:0], upper bits 0.
- `sram_row` and `sram_wdata` are held stable from PRE entry through RESP.

## Timing
- Reset values: state IDLE; all strobes, readies and sram_* controls 0; `sram_bl_mask`=1111; `rsp_*`=0; last-served = B.
- Reset mid-operation: the in-flight request is dropped with no response. Outputs take reset values after the rst edge.
- With defaults, request accepted at edge E0:
  - PRE: cycle 1.
  - ACC: cycles 2–3.
  - Read: SENSE cycle 4, `rsp_valid` cycle 5.
  - Write: `rsp_valid` cycle 4.
- Read latency = PRE_CYC + WL_CYC + 2. Write latency = PRE_CYC + WL_CYC + 1.
- Both readies are 0 outside IDLE. Earliest next acceptance is the cycle after RESP.
- A request held valid and not granted must remain stable. It is granted on the next IDLE cycle if the other requester was served last.

## Configuration
- `SRAM_CTRL_ERR_EN` defined:
  - Adds output port `rsp_err` (1 bit, reset 0).
  - A conf=11 request goes IDLE→RESP directly with no macro activity, and responds with `rsp_err=1`, `rsp_rdata=0`.
- Undefined:
  - No `rsp_err` port.
  - conf=11 is treated as 32-bit.

## Test plan
- A write, conf=10, addr=0x06 (row 1, sel 2), wdata=0xA5 → mask 1011 during ACC cycles 2–3; `sram_wdata`=0xA5A5A5A5; `sram_we`=1; `rsp_valid` cycle 4, id 0.
- B read, conf=01, sel[0]=1, macro returns 0x12345678 → mask 0011; `sram_sae` cycle 4; `rsp_rdata`=0x00001234 cycle 5, id 1.
- A and B valid together from reset, both held → A granted first, B on the IDLE cycle after A's RESP, then A again.
- rst asserted during ACC of a 32-bit write → next cycle all controls 0, mask 1111, no `rsp_valid`; a subsequent request completes normally.
- PRE_CYC=2, WL_CYC=3, 32-bit read → `rsp_valid` exactly 7 cycles after the accept edge; mask 0000 for 3 cycles.
- With `SRAM_CTRL_ERR_EN`, conf=11 → no `sram_pre_en`/`sram_wl_en`; `rsp_valid`+`rsp_err` in cycle 1. Without it → normal 32-bit timing.
